// File: rtl/key_pkg.sv
// Shared types and constants for the push-button debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } key_state_t;

  localparam int PRESS_COUNT_W = 8;

endpackage

// File: rtl/key_sync.sv
// N-flop synchronizer for an asynchronous active-low input; resets to 1 (released).
module key_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/key_debouncer.sv
// Debounces one active-low button into a level, press/release/long-press pulses and a press count.
// Optional auto-repeat after a long press is enabled by defining KEY_AUTOREPEAT_EN.
module key_debouncer
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     key_n,
  output logic                     key_level,
  output logic                     press_pulse,
  output logic                     release_pulse,
  output logic                     long_pulse,
  output logic [PRESS_COUNT_W-1:0] press_count
);

  localparam int CNT_W  = $clog2(LONG_CYCLES + 1);
  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(LONG_CYCLES);
  localparam logic [DCNT_W-1:0] DDEB_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

  logic              w_s;
  key_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DCNT_W-1:0] r_dcnt;
  logic              r_long_done;

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] r_rcnt;
`else
  logic w_unused_repeat;
  assign w_unused_repeat = (REPEAT_CYCLES > 0);
`endif

  key_sync #(.STAGES(2)) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .i_d  (key_n),
    .o_q  (w_s)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state       <= RELEASED;
      r_cnt         <= '0;
      r_dcnt        <= '0;
      r_long_done   <= 1'b0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= '0;
`ifdef KEY_AUTOREPEAT_EN
      r_rcnt        <= '0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      case (r_state)
        RELEASED: begin
          if (!w_s) begin
            r_state <= PRESS_CHK;
            r_cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (w_s) begin
            r_state <= RELEASED;
          end else if (r_cnt == DEB_LAST) begin
            r_state     <= PRESSED;
            key_level   <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + 1'b1;
            r_cnt       <= '0;
            r_long_done <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            r_rcnt      <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          // cnt holds total time in PRESSED for this press; frozen while checking a release
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (r_cnt == LONG_LAST && !r_long_done) begin
            long_pulse  <= 1'b1;
            r_long_done <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            r_rcnt      <= '0;
          end else if (r_long_done) begin
            if (r_rcnt == RPT_LAST) begin
              press_pulse <= 1'b1;
              press_count <= press_count + 1'b1;
              r_rcnt      <= '0;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
`endif
          end
          if (w_s) begin
            r_state <= RELEASE_CHK;
            r_dcnt  <= '0;
          end
        end
        RELEASE_CHK: begin
          if (!w_s) begin
            r_state <= PRESSED;
          end else if (r_dcnt == DDEB_LAST) begin
            r_state       <= RELEASED;
            key_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        default: r_state <= RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: run-length reference model plus directed literal checkpoints.
module tb_key_debouncer;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       key_n = 1'b1;
  logic       key_level, press_pulse, release_pulse, long_pulse;
  logic [7:0] press_count;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .key_n         (key_n),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .press_count   (press_count)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a level flips once the synchronized input has disagreed with it
  // for DEB+1 consecutive samples; time spent settled in the pressed level drives long/repeat.
  int m_k1 = 1, m_k2 = 1, m_s = 1;
  int m_level = 0, m_run = 0, m_held = 0, m_long_done = 0, m_rep = 0, m_cnt = 0;
  bit m_settled;
  int e_level = 0, e_press = 0, e_rel = 0, e_long = 0;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_k1 = 1; m_k2 = 1; m_level = 0; m_run = 0; m_held = 0;
      m_long_done = 0; m_rep = 0; m_cnt = 0;
      e_level = 0; e_press = 0; e_rel = 0; e_long = 0;
    end else begin
      m_s  = m_k2;
      m_k2 = m_k1;
      m_k1 = int'(key_n);
      e_press = 0; e_rel = 0; e_long = 0;
      m_settled = (m_level == 1) && (m_run == 0);
      if (m_settled) begin
        if (m_held == LONG - 1 && m_long_done == 0) begin
          e_long = 1; m_long_done = 1; m_rep = 0;
        end else if (AUTOREP && m_long_done == 1) begin
          if (m_rep == REP - 1) begin
            e_press = 1; m_cnt = (m_cnt + 1) % 256; m_rep = 0;
          end else begin
            m_rep++;
          end
        end
        if (m_held < LONG) m_held++;
      end
      if ((m_s == 0 ? 1 : 0) != m_level) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_run = 0;
          m_level = 1 - m_level;
          if (m_level == 1) begin
            e_press = 1; m_cnt = (m_cnt + 1) % 256;
            m_held = 0; m_long_done = 0; m_rep = 0;
          end else begin
            e_rel = 1;
          end
        end
      end else begin
        m_run = 0;
      end
      e_level = m_level;
    end
  end

  always @(negedge clk) begin
    if (nrst && chk_en) begin
      chk("model key_level", key_level, e_level);
      chk("model press_pulse", press_pulse, e_press);
      chk("model release_pulse", release_pulse, e_rel);
      chk("model long_pulse", long_pulse, e_long);
      chk("model press_count", press_count, m_cnt);
    end
  end

  // Entered and left at posedge+2: value v is sampled on exactly n rising edges.
  task automatic hold(input logic v, input int n);
    key_n = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " key_level"}, key_level, 0);
    chk({tag, " press_pulse"}, press_pulse, 0);
    chk({tag, " release_pulse"}, release_pulse, 0);
    chk({tag, " long_pulse"}, long_pulse, 0);
    chk({tag, " press_count"}, press_count, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    @(posedge clk);
    #2;
    nrst   = 1'b1;
    chk_en = 1'b1;
    hold(1'b1, 5);

    // bounce shorter than the debounce window
    hold(1'b0, 2); hold(1'b1, 1); hold(1'b0, 2); hold(1'b1, 12);
    chk("bounce key_level", key_level, 0);
    chk("bounce press_count", press_count, 0);

    // clean press: pulse after edge E0+6, release with same latency
    hold(1'b0, 6);
    chk("clean pulse early", press_pulse, 0);
    hold(1'b0, 1);
    chk("clean press_pulse", press_pulse, 1);
    chk("clean key_level", key_level, 1);
    chk("clean press_count", press_count, 1);
    hold(1'b0, 1);
    chk("clean pulse width", press_pulse, 0);
    hold(1'b0, 2);
    hold(1'b1, 6);
    chk("clean release early", release_pulse, 0);
    hold(1'b1, 1);
    chk("clean release_pulse", release_pulse, 1);
    chk("clean level off", key_level, 0);
    hold(1'b1, 5);

    // long press: long_pulse 20 cycles after press_pulse
    hold(1'b0, 7);
    chk("long press_pulse", press_pulse, 1);
    hold(1'b0, 19);
    chk("long early", long_pulse, 0);
    hold(1'b0, 1);
    chk("long_pulse", long_pulse, 1);
    hold(1'b0, 1);
    chk("long width", long_pulse, 0);
    hold(1'b0, 12);
    hold(1'b1, 7);
    chk("long release_pulse", release_pulse, 1);
    hold(1'b1, 5);

    // release bounce before long: two check edges delay long_pulse by two
    hold(1'b0, 7); hold(1'b0, 8); hold(1'b1, 2);
    hold(1'b0, 11);
    chk("rbounce long early", long_pulse, 0);
    hold(1'b0, 1);
    chk("rbounce long_pulse", long_pulse, 1);
    chk("rbounce level", key_level, 1);
    hold(1'b0, 5); hold(1'b1, 2); hold(1'b0, 10);
    chk("rbounce level kept", key_level, 1);
    hold(1'b1, 12);

    // wrap: clear count, then 256 presses
    nrst = 1'b0;
    #1;
    chk("reset count", press_count, 0);
    @(posedge clk);
    #2;
    nrst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      hold(1'b0, 10);
      hold(1'b1, 10);
      if (i == 254) chk("count 255", press_count, 255);
    end
    chk("wrap count", press_count, 0);

    // reset while PRESSED with button still held: fresh press afterwards
    hold(1'b0, 10);
    chk("pre-reset level", key_level, 1);
    chk("pre-reset count", press_count, 1);
    nrst = 1'b0;
    #1;
    all_zero("async reset pressed");
    @(posedge clk);
    #2;
    nrst = 1'b1;
    hold(1'b0, 6);
    chk("post-reset early", press_pulse, 0);
    hold(1'b0, 1);
    chk("post-reset press_pulse", press_pulse, 1);
    chk("post-reset count", press_count, 1);
    hold(1'b0, 3);
    hold(1'b1, 12);

    // reset mid PRESS_CHK
    hold(1'b0, 4);
    nrst = 1'b0;
    #1;
    all_zero("async reset presschk");
    @(posedge clk);
    #2;
    key_n = 1'b1;
    nrst  = 1'b1;
    hold(1'b1, 8);
    chk("presschk reset count", press_count, 0);
    hold(1'b0, 10);
    chk("after reset press", press_count, 1);
    hold(1'b1, 10);

`ifdef KEY_AUTOREPEAT_EN
    hold(1'b0, 7);
    chk("rep first press", press_pulse, 1);
    hold(1'b0, 20);
    chk("rep long", long_pulse, 1);
    hold(1'b0, 5);
    chk("rep pulse 1", press_pulse, 1);
    hold(1'b0, 5);
    chk("rep pulse 2", press_pulse, 1);
    chk("rep count", press_count, 4);
    hold(1'b0, 4);
    hold(1'b1, 12);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
